packet_adder_arb: RTL and testbench
===================================

Name: packet_adder_arb

Overview:
- Shares one packet_adder instance between NREQ requester streams.
- Grants the adder input port to one requester for a whole packet, round-robin between packets.
- Records the owner of each granted packet in an in-order ID FIFO.
- Routes the adder's result stream back to that packet's owner, so several packets can be in flight inside the adder pipeline.

Parameters:
- WIDTH, 8, operand width; adder result is WIDTH+1.
- NREQ, 4, number of requesters (2..8).
- DEPTH, 4, max packets granted but not yet fully returned (ID FIFO depth, power of 2).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- req_a  input  NREQ*WIDTH  operand A per requester, lane i at [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B per requester
- req_valid  input  NREQ  beat valid per requester
- req_last  input  NREQ  last beat of packet per requester
- req_ready  output  NREQ  beat accepted when valid&ready
- add_a  output  WIDTH  to adder in_a
- add_b  output  WIDTH  to adder in_b
- add_valid  output  1  to adder in_valid
- add_last  output  1  to adder in_last
- add_ready  input  1  from adder in_ready
- add_sum  input  WIDTH+1  from adder out_sum
- add_out_valid  input  1  from adder out_valid
- add_out_last  input  1  from adder out_last
- add_out_ready  output  1  to adder out_ready
- resp_sum  output  WIDTH+1  result, broadcast to all lanes
- resp_valid  output  NREQ  result valid, one-hot to owner
- resp_last  output  NREQ  last result beat, one-hot to owner
- resp_ready  input  NREQ  per-requester result ready
- busy  output  1  high in GRANT state
- err  output  1  sticky: adder output seen with ID FIFO empty

Behaviour:
- Reset (rst_n low at clk edge), whether idle or mid-operation:
  - state=IDLE, rr_ptr=0, FIFO empty, err=0.
  - In-flight packets are dropped; no partial beats are completed.
  - Resulting outputs: req_ready=0, add_valid=0, add_out_ready=0, resp_valid=0, resp_last=0, busy=0.
- Input FSM, states IDLE and GRANT:
  - IDLE: if any req_valid and FIFO not full, select the first requester with valid at or after rr_ptr, wrapping modulo NREQ. Register grant_id, push grant_id into the FIFO, go to GRANT.
  - IDLE, no request or FIFO full: stay in IDLE, all req_ready=0, add_valid=0.
  - Arbitration costs exactly one cycle: a request seen in IDLE at cycle t can first transfer at cycle t+1.
  - GRANT: add_a/add_b/add_valid/add_last come combinationally from lane grant_id; req_ready[grant_id]=add_ready; all other req_ready=0.
  - GRANT exit: on a beat with req_valid&add_ready&req_last for grant_id, rr_ptr=(grant_id+1) mod NREQ, go to IDLE.
  - No back-to-back grant in the same cycle; one IDLE cycle sits between packets.
  - req_valid dropping mid-packet inserts a bubble; the grant is held until last.
- Return path:
  - h = FIFO head ID.
  - When FIFO not empty: resp_valid[h]=add_out_valid, resp_last[h]=add_out_last, add_out_ready=resp_ready[h]. All other lanes have valid=0 and last=0.
  - resp_sum=add_sum always.
  - Pop on add_out_valid&add_out_ready&add_out_last.
- FIFO boundaries:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - When full, no new grant is made; the grant in progress continues.
  - When empty: add_out_ready=0 and resp_valid=0. If add_out_valid=1, err is set and stays set until reset.
  - Pointers wrap modulo DEPTH.
- Sums are not modified: WIDTH+1 bits pass through unchanged; carry is preserved.

Test Plan:
- Single packet, WIDTH=8, adder LAT=2:
  - Stimulus: req0 sends a={1,2,3}, b={4,5,6}, last on beat 3, resp_ready=1.
  - Response: lane 0 gets resp_sum 5,7,9 with resp_last[0] on 9; other lanes resp_valid=0; busy falls the cycle after beat 3.
- Overflow carry: req1 sends a=255, b=255, single-beat packet -> resp_sum=510 (9'h1FE) on lane 1 with resp_last[1]=1.
- Round-robin:
  - Stimulus: req0, req2, req3 all valid from the same cycle, rr_ptr=0, each a 2-beat packet.
  - Response: grant order 0, 2, 3; results return in that order to the matching lanes; rr_ptr ends at 0, showing the wrap from lane 3.
- Backpressure:
  - Stimulus: resp_ready[0] held low for 5 cycles during a 3-beat packet.
  - Response: add_out_ready=0 for those cycles; no beat is lost or duplicated; the adder stalls req_ready via add_ready.
- FIFO full:
  - Stimulus: DEPTH=4, resp_ready all 0, req0..req3 each send a 1-beat packet, then req1 requests again.
  - Response: 4 grants are made; the fifth is withheld (req_ready[1]=0). After resp_ready goes high and one pop, the fifth is granted.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 for 1 cycle after beat 2 of a 4-beat req2 packet.
  - Response: next cycle busy=0, all req_ready=0, resp_valid=0, err=0. A new req0 packet then completes normally, with rr_ptr starting from 0.

Source files
------------

// File: rtl/packet_adder_arb.sv
// packet_adder_arb: shares one packet_adder between NREQ requester streams.
// Whole-packet round-robin grant on the input side; an in-order ID FIFO of
// packet owners steers the adder's result stream back to each owner.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_a/b/valid/last  per-lane operand beats (lane i at [i*WIDTH +: WIDTH])
//   req_ready           per-lane beat accept
//   add_a/b/valid/last  beat stream into the shared adder, add_ready back
//   add_sum/out_valid/out_last from the adder, add_out_ready back
//   resp_sum            adder sum broadcast to all lanes
//   resp_valid/last     one-hot to the owner of the packet at the FIFO head
//   resp_ready          per-lane result accept
//   busy                a packet is currently granted
//   err                 sticky: adder produced output with no packet owner

module packet_adder_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_valid,
    output logic                  add_last,
    input  logic                  add_ready,
    input  logic [WIDTH:0]        add_sum,
    input  logic                  add_out_valid,
    input  logic                  add_out_last,
    output logic                  add_out_ready,
    output logic [WIDTH:0]        resp_sum,
    output logic [NREQ-1:0]       resp_valid,
    output logic [NREQ-1:0]       resp_last,
    input  logic [NREQ-1:0]       resp_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] next_ptr;

    logic [IDW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           fifo_full;
    logic           fifo_empty;
    logic [IDW-1:0] head;

    logic [IDW-1:0] pick;
    logic           pick_ok;
    logic [IDW-1:0] sel;
    int             idx;

    logic           push;
    logic           pop;
    logic           last_beat;

    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    // Scan offsets from far to near so the nearest valid lane at or
    // after rr_ptr is the one left in pick.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = IDW'(idx);
            if (req_valid[sel]) begin
                pick    = sel;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        add_a     = '0;
        add_b     = '0;
        add_valid = 1'b0;
        add_last  = 1'b0;
        req_ready = '0;
        if (state == GRANT) begin
            add_a               = req_a[int'(grant_id)*WIDTH +: WIDTH];
            add_b               = req_b[int'(grant_id)*WIDTH +: WIDTH];
            add_valid           = req_valid[grant_id];
            add_last            = req_last[grant_id];
            req_ready[grant_id] = add_ready;
        end
    end

    always_comb begin
        resp_valid    = '0;
        resp_last     = '0;
        add_out_ready = 1'b0;
        if (!fifo_empty) begin
            resp_valid[head] = add_out_valid;
            resp_last[head]  = add_out_last;
            add_out_ready    = resp_ready[head];
        end
    end

    assign resp_sum = add_sum;
    assign busy     = (state == GRANT);

    assign push = (state == IDLE) && pick_ok && !fifo_full;
    assign pop  = add_out_valid && add_out_ready && add_out_last;

    assign last_beat = (state == GRANT) && req_valid[grant_id]
                       && add_ready && req_last[grant_id];

    assign next_ptr = (grant_id == IDW'(NREQ - 1)) ? '0
                      : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (push) begin
                        grant_id <= pick;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (last_beat) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                fifo_mem[wr_ptr] <= pick;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            unique case (1'b1)
                (push && !pop): count <= count + 1'b1;
                (pop && !push): count <= count - 1'b1;
                default:        count <= count;
            endcase

            if (fifo_empty && add_out_valid) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packet_adder_arb.sv
// tb_packet_adder_arb: directed bench for packet_adder_arb with an elastic
// adder model and an ownership/result scoreboard.

module tb_packet_adder_arb;

    localparam int W = 8;
    localparam int N = 4;
    localparam int D = 4;
    localparam int LAT = 2;

    logic             clk;
    logic             rst_n;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic             add_valid;
    logic             add_last;
    logic             add_ready;
    logic [W:0]       add_sum;
    logic             add_out_valid;
    logic             add_out_last;
    logic             add_out_ready;
    logic [W:0]       resp_sum;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_last;
    logic [N-1:0]     resp_ready;
    logic             busy;
    logic             err;

    packet_adder_arb #(.WIDTH(W), .NREQ(N), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b),
        .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b),
        .add_valid(add_valid), .add_last(add_last),
        .add_ready(add_ready),
        .add_sum(add_sum), .add_out_valid(add_out_valid),
        .add_out_last(add_out_last), .add_out_ready(add_out_ready),
        .resp_sum(resp_sum), .resp_valid(resp_valid),
        .resp_last(resp_last), .resp_ready(resp_ready),
        .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors;
    int checks;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Elastic adder model: results emerge in order, at least LAT
    // cycles after acceptance; cap bounds how many it holds.
    typedef struct {
        logic [W:0] s;
        logic       l;
        int         age;
    } ab_t;

    ab_t        pq[$];
    int         cap;
    logic       inj;
    logic       m_rdy;
    logic       m_ov;
    logic       m_last;
    logic [W:0] m_sum;

    assign add_ready     = m_rdy;
    assign add_out_valid = m_ov | inj;
    assign add_out_last  = m_last;
    assign add_sum       = m_sum;

    initial begin
        ab_t e;
        m_rdy  = 1'b0;
        m_ov   = 1'b0;
        m_last = 1'b0;
        m_sum  = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                pq.delete();
            end else begin
                if (m_ov && add_out_ready) void'(pq.pop_front());
                foreach (pq[k]) pq[k].age++;
                if (add_valid && m_rdy) begin
                    e.s   = {1'b0, add_a} + {1'b0, add_b};
                    e.l   = add_last;
                    e.age = 0;
                    pq.push_back(e);
                end
            end
            m_rdy <= (pq.size() < cap);
            if (pq.size() > 0 && pq[0].age >= LAT) begin
                m_ov   <= 1'b1;
                m_sum  <= pq[0].s;
                m_last <= pq[0].l;
            end else begin
                m_ov   <= 1'b0;
                m_sum  <= '0;
                m_last <= 1'b0;
            end
        end
    end

    // Requester stimulus: one beat queue per lane.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         l;
    } beat_t;

    beat_t lane_q [N][$];

    task automatic push(input int ln, input int a, input int b,
                        input logic l);
        beat_t bt;
        bt.a = W'(a);
        bt.b = W'(b);
        bt.l = l;
        lane_q[ln].push_back(bt);
    endtask

    initial begin
        logic [N-1:0] pop_now;
        req_a     = '0;
        req_b     = '0;
        req_valid = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            pop_now = rst_n ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pop_now[i] && lane_q[i].size() > 0)
                    void'(lane_q[i].pop_front());
                if (lane_q[i].size() > 0) begin
                    req_a[i*W +: W] = lane_q[i][0].a;
                    req_b[i*W +: W] = lane_q[i][0].b;
                    req_last[i]     = lane_q[i][0].l;
                    req_valid[i]    = 1'b1;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every accepted beat from lane i owes lane i one result,
    // results return in acceptance order, packets are never interleaved.
    typedef struct {
        int   lane;
        int   sum;
        logic l;
    } res_t;

    res_t exp_q[$];
    res_t ret_log[$];
    int   gq[$];
    int   grant_ret[$];
    int   fire_cnt [N];
    int   owner;

    initial begin
        logic [N-1:0] in_fire;
        logic [N-1:0] out_fire;
        res_t         r;
        res_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                owner = -1;
            end else begin
                in_fire  = req_valid & req_ready;
                out_fire = resp_valid & resp_ready;
                chk("sum_pass", 32'(resp_sum), 32'(add_sum));
                chk("resp_onehot", 32'($countones(resp_valid) <= 1), 1);
                chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
                chk("in_path", 32'(|in_fire), 32'(add_valid & add_ready));
                chk("out_path", 32'(|out_fire),
                    32'(add_out_valid & add_out_ready));
                for (int i = 0; i < N; i++) begin
                    if (in_fire[i]) begin
                        fire_cnt[i]++;
                        if (owner < 0) begin
                            owner = i;
                            gq.push_back(i);
                            grant_ret.push_back(ret_log.size());
                        end
                        chk("pkt_owner", i, owner);
                        r.lane = i;
                        r.sum  = int'(req_a[i*W +: W]) + int'(req_b[i*W +: W]);
                        r.l    = req_last[i];
                        exp_q.push_back(r);
                        if (req_last[i]) owner = -1;
                    end
                end
                for (int j = 0; j < N; j++) begin
                    if (out_fire[j]) begin
                        r.lane = j;
                        r.sum  = int'(resp_sum);
                        r.l    = resp_last[j];
                        ret_log.push_back(r);
                        if (exp_q.size() == 0) begin
                            chk("resp_extra", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("resp_lane", j, e.lane);
                            chk("resp_sum", r.sum, e.sum);
                            chk("resp_last", 32'(r.l), 32'(e.l));
                        end
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        gq.delete();
        grant_ret.delete();
        ret_log.delete();
    endtask

    task automatic wait_idle();
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            n++;
            done = !busy && exp_q.size() == 0 && pq.size() == 0;
            for (int i = 0; i < N; i++)
                if (lane_q[i].size() > 0) done = 0;
        end
        chk("idle_timeout", 32'(done), 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_fire(input int ln, input int target);
        int n;
        n = 0;
        while (fire_cnt[ln] < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("fire_timeout", 32'(fire_cnt[ln] >= target), 1);
    endtask

    task automatic chk_grants(input int e[$]);
        chk("grant_count", gq.size(), e.size());
        for (int k = 0; k < e.size(); k++)
            if (k < gq.size()) chk("grant_order", gq[k], e[k]);
    endtask

    task automatic chk_ret(input int ln[$], input int sm[$],
                           input int ls[$]);
        chk("ret_count", ret_log.size(), ln.size());
        for (int k = 0; k < ln.size(); k++) begin
            if (k < ret_log.size()) begin
                chk("ret_lane", ret_log[k].lane, ln[k]);
                chk("ret_sum", ret_log[k].sum, sm[k]);
                chk("ret_last", 32'(ret_log[k].l), ls[k]);
            end
        end
    endtask

    initial begin
        int   base;
        bit   stall;
        int   eg[$];
        int   el[$];
        int   es[$];
        int   ex[$];
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        resp_ready = '0;
        inj        = 1'b0;
        cap        = 8;
        owner      = -1;
        for (int i = 0; i < N; i++) fire_cnt[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_add_valid", 32'(add_valid), 0);
        chk("rst_out_ready", 32'(add_out_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_last", 32'(resp_last), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // round robin from rr_ptr=0: lanes 0,2,3 together
        clear_logs();
        resp_ready = '1;
        push(0, 10, 1, 0); push(0, 11, 1, 1);
        push(2, 20, 2, 0); push(2, 21, 2, 1);
        push(3, 30, 3, 0); push(3, 31, 3, 1);
        wait_idle();
        eg = {0, 2, 3};
        chk_grants(eg);
        el = {0, 0, 2, 2, 3, 3};
        es = {11, 12, 22, 23, 33, 34};
        ex = {0, 1, 0, 1, 0, 1};
        chk_ret(el, es, ex);

        // single 3-beat packet on lane 0
        clear_logs();
        base = fire_cnt[0];
        push(0, 1, 4, 0); push(0, 2, 5, 0); push(0, 3, 6, 1);
        wait_fire(0, base + 1);
        @(negedge clk);
        chk("busy_mid", 32'(busy), 1);
        wait_fire(0, base + 3);
        @(negedge clk);
        chk("busy_fall", 32'(busy), 0);
        wait_idle();
        el = {0, 0, 0};
        es = {5, 7, 9};
        ex = {0, 0, 1};
        chk_ret(el, es, ex);

        // carry out of the top bit
        clear_logs();
        push(1, 255, 255, 1);
        wait_idle();
        el = {1};
        es = {510};
        ex = {1};
        chk_ret(el, es, ex);

        // result backpressure on lane 0 with a shallow adder
        clear_logs();
        cap  = 2;
        base = fire_cnt[0];
        push(0, 100, 1, 0); push(0, 101, 2, 0); push(0, 102, 3, 1);
        wait_fire(0, base + 1);
        #2 resp_ready[0] = 1'b0;
        stall = 0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_ready", 32'(add_out_ready), 0);
            if (busy && req_valid[0] && !req_ready[0]) stall = 1;
        end
        @(posedge clk);
        #2 resp_ready[0] = 1'b1;
        chk("bp_stall", 32'(stall), 1);
        wait_idle();
        cap = 8;
        el = {0, 0, 0};
        es = {101, 103, 105};
        ex = {0, 0, 1};
        chk_ret(el, es, ex);

        // ID FIFO full: rr_ptr is 1 here, so grants go 1,2,3,0
        clear_logs();
        resp_ready = '0;
        push(0, 1, 1, 1); push(1, 2, 2, 1); push(2, 3, 3, 1);
        push(3, 4, 4, 1); push(1, 5, 5, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("full_grants", gq.size(), 4);
        chk("full_req_ready", 32'(req_ready), 0);
        chk("full_busy", 32'(busy), 0);
        @(posedge clk);
        #2 resp_ready = '1;
        wait_idle();
        eg = {1, 2, 3, 0, 1};
        chk_grants(eg);
        if (grant_ret.size() == 5)
            chk("fifth_after_pop", 32'(grant_ret[4] >= 1), 1);
        el = {1, 2, 3, 0, 1};
        es = {4, 6, 8, 2, 10};
        ex = {1, 1, 1, 1, 1};
        chk_ret(el, es, ex);

        // reset after beat 2 of a 4-beat lane 2 packet
        clear_logs();
        base = fire_cnt[2];
        push(2, 1, 0, 0); push(2, 2, 0, 0);
        push(2, 3, 0, 0); push(2, 4, 0, 1);
        wait_fire(2, base + 2);
        #2 rst_n = 1'b0;
        lane_q[2].delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_req_ready", 32'(req_ready), 0);
        chk("mrst_resp_valid", 32'(resp_valid), 0);
        chk("mrst_add_valid", 32'(add_valid), 0);
        chk("mrst_err", 32'(err), 0);
        clear_logs();
        push(0, 7, 8, 1);
        push(3, 9, 9, 1);
        wait_idle();
        eg = {0, 3};
        chk_grants(eg);
        el = {0, 3};
        es = {15, 18};
        ex = {1, 1};
        chk_ret(el, es, ex);

        // adder output with no owner sets sticky err
        chk("err_clear", 32'(err), 0);
        @(posedge clk);
        #2 inj = 1'b1;
        @(negedge clk);
        chk("orphan_resp_valid", 32'(resp_valid), 0);
        chk("orphan_out_ready", 32'(add_out_ready), 0);
        @(posedge clk);
        #2 inj = 1'b0;
        @(negedge clk);
        chk("err_set", 32'(err), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", 32'(err), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("err_reset", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
